// File: rtl/minmax_pkg.sv
// -----------------------------------------------------------------------------
// minmax_pkg
// Shared types and widths for the minmax_seq frame min/max tracker.
//   WORD_W  : width of one operand word
//   CNT_W   : width of the frame word counter and index fields
//   state_t : controller state encoding
// -----------------------------------------------------------------------------
package minmax_pkg;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP_MAX,
        S_CMP_MIN,
        S_DONE
    } state_t;

endpackage : minmax_pkg

// File: rtl/cmp4.sv
// -----------------------------------------------------------------------------
// cmp4
// Combinational unsigned magnitude comparator.
//   a, b : operands (WORD_W bits)
//   gt   : a >  b
//   eq   : a == b
//   lt   : a <  b
// -----------------------------------------------------------------------------
module cmp4
    import minmax_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              gt,
    output logic              eq,
    output logic              lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule : cmp4

// File: rtl/minmax_seq.sv
// -----------------------------------------------------------------------------
// minmax_seq
// Accepts a frame of 4-bit unsigned words over a valid/ready stream and
// reports the frame maximum, minimum and word count. A single comparator is
// time-shared: every word after the first spends one cycle against max and
// one against min. A frame closes on in_last, or is force-closed once
// MAX_WORDS words have been taken (out_trunc=1).
//
// Parameter
//   MAX_WORDS   : forced frame length, 1..15
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_data/in_last valid
//   in_ready    : a word is accepted this cycle (only while idle)
//   in_data     : operand word
//   in_last     : last word of its frame
//   out_valid   : result valid, held until out_ready
//   out_ready   : consumer takes the result
//   out_max     : frame maximum
//   out_min     : frame minimum
//   out_count   : words in the frame
//   out_trunc   : frame ended by MAX_WORDS rather than in_last
// Optional (macro MINMAX_IDX_EN)
//   out_max_idx : 0-based position of the first occurrence of the maximum
//   out_min_idx : 0-based position of the first occurrence of the minimum
// -----------------------------------------------------------------------------
module minmax_seq
    import minmax_pkg::*;
#(
    parameter int MAX_WORDS = 15
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_max,
    output logic [WORD_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_trunc
`ifdef MINMAX_IDX_EN
    ,
    output logic [CNT_W-1:0]  out_max_idx,
    output logic [CNT_W-1:0]  out_min_idx
`endif
);

    state_t            state;
    logic [WORD_W-1:0] hold;        // word waiting for its two comparisons
    logic              first_word;  // 1: the next accepted word opens a frame
    logic              frame_end;   // frame closed; result due after compares
`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0]  hold_idx;    // frame position of the held word
`endif

    logic              accept;
    logic [CNT_W-1:0]  cnt_next;
    logic              at_limit;
    logic              end_now;
    logic [WORD_W-1:0] cmp_b;
    logic              gt;
    logic              eq;
    logic              lt;
    logic              take;

    assign accept   = in_valid && in_ready;
    assign cnt_next = first_word ? CNT_W'(1) : out_count + CNT_W'(1);
    assign at_limit = (cnt_next == CNT_W'(MAX_WORDS));
    assign end_now  = in_last || at_limit;

    // The one comparator always sees the held word against the extreme that
    // the current state is refining.
    assign cmp_b = (state == S_CMP_MIN) ? out_min : out_max;

    cmp4 u_cmp (
        .a  (hold),
        .b  (cmp_b),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // Equal values never replace an extreme, so ties keep the earlier word.
    assign take = eq ? 1'b0 : ((state == S_CMP_MAX) ? gt : lt);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation and mismatch the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_count   <= '0;
            out_trunc   <= 1'b0;
            hold        <= '0;
            first_word  <= 1'b1;
            frame_end   <= 1'b0;
`ifdef MINMAX_IDX_EN
            out_max_idx <= '0;
            out_min_idx <= '0;
            hold_idx    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_count <= cnt_next;
                        out_trunc <= at_limit && !in_last;
                        frame_end <= end_now;
                        if (first_word) begin
                            out_max    <= in_data;
                            out_min    <= in_data;
                            first_word <= 1'b0;
`ifdef MINMAX_IDX_EN
                            out_max_idx <= '0;
                            out_min_idx <= '0;
`endif
                            if (end_now) begin
                                state     <= S_DONE;
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                            end
                        end else begin
                            hold     <= in_data;
`ifdef MINMAX_IDX_EN
                            hold_idx <= out_count;
`endif
                            state    <= S_CMP_MAX;
                            in_ready <= 1'b0;
                        end
                    end
                end

                S_CMP_MAX: begin
                    if (take) begin
                        out_max     <= hold;
`ifdef MINMAX_IDX_EN
                        out_max_idx <= hold_idx;
`endif
                    end
                    state <= S_CMP_MIN;
                end

                S_CMP_MIN: begin
                    if (take) begin
                        out_min     <= hold;
`ifdef MINMAX_IDX_EN
                        out_min_idx <= hold_idx;
`endif
                    end
                    if (frame_end) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state      <= S_IDLE;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        first_word <= 1'b1;
                        frame_end  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : minmax_seq

// File: tb/tb_minmax_seq.sv
// -----------------------------------------------------------------------------
// tb_minmax_seq
// Self-checking bench for minmax_seq (MAX_WORDS=4). A queue holds the words of
// the open frame; when a frame closes the expected max/min/count/trunc (and
// indices when MINMAX_IDX_EN is defined) are computed from the queue and
// compared with the DUT result.
// -----------------------------------------------------------------------------
module tb_minmax_seq;
    import minmax_pkg::*;

    localparam int MW = 4;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              in_valid  = 1'b0;
    logic [WORD_W-1:0] in_data   = '0;
    logic              in_last   = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_max;
    logic [WORD_W-1:0] out_min;
    logic [CNT_W-1:0]  out_count;
    logic              out_trunc;
`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0]  out_max_idx;
    logic [CNT_W-1:0]  out_min_idx;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int frame_q[$];

    always #5 clk = ~clk;

    minmax_seq #(.MAX_WORDS(MW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_count   (out_count),
        .out_trunc   (out_trunc)
`ifdef MINMAX_IDX_EN
        ,
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx)
`endif
    );

    // Closes the modelled frame: latency, result, stall stability, handoff.
    task automatic drain_frame(input bit exp_trunc, input int hold_cycles);
        int emax, emin, imax, imin, ecount, lat, exp_lat;
        bit seen;
        emax = frame_q[0]; emin = frame_q[0]; imax = 0; imin = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i] > emax) begin emax = frame_q[i]; imax = i; end
            if (frame_q[i] < emin) begin emin = frame_q[i]; imin = i; end
        end
        ecount  = frame_q.size();
        exp_lat = (ecount == 1) ? 0 : 2;

        lat = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin seen = 1; break; end
            lat++;
        end
        vectors++;
        if (!seen || lat != exp_lat) begin
            miscompares++;
            $display("FAIL latency: out_valid seen=%0b after %0d cycles, required after %0d",
                     seen, lat, exp_lat);
            frame_q.delete();
            return;
        end

        vectors++;
        if (out_max !== WORD_W'(emax)) begin
            miscompares++;
            $display("FAIL out_max: got %0d, required %0d", out_max, emax);
        end
        vectors++;
        if (out_min !== WORD_W'(emin)) begin
            miscompares++;
            $display("FAIL out_min: got %0d, required %0d", out_min, emin);
        end
        vectors++;
        if (out_count !== CNT_W'(ecount)) begin
            miscompares++;
            $display("FAIL out_count: got %0d, required %0d", out_count, ecount);
        end
        vectors++;
        if (out_trunc !== exp_trunc) begin
            miscompares++;
            $display("FAIL out_trunc: got %0b, required %0b", out_trunc, exp_trunc);
        end
`ifdef MINMAX_IDX_EN
        vectors++;
        if (out_max_idx !== CNT_W'(imax) || out_min_idx !== CNT_W'(imin)) begin
            miscompares++;
            $display("FAIL idx: got max_idx=%0d min_idx=%0d, required %0d %0d",
                     out_max_idx, out_min_idx, imax, imin);
        end
`endif

        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== WORD_W'(emax) ||
                out_min !== WORD_W'(emin) || out_count !== CNT_W'(ecount)) begin
                miscompares++;
                $display("FAIL stall_stable: valid=%0b ready=%0b max=%0d min=%0d cnt=%0d, required 1 0 %0d %0d %0d",
                         out_valid, in_ready, out_max, out_min, out_count, emax, emin, ecount);
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff: out_valid=%0b after out_ready, required 0", out_valid);
        end
        frame_q.delete();
    endtask

    // Offers one word, waits for acceptance, and closes the frame if the
    // model says this word ended it.
    task automatic push_word(input logic [WORD_W-1:0] d, input logic last,
                             input int hold_cycles);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin got = 1; break; end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
            return;
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        frame_q.push_back(int'(d));
        if (last || frame_q.size() == MW)
            drain_frame(!last, hold_cycles);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_max !== '0 || out_min !== '0 ||
            out_count !== '0 || out_trunc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b ready=%0b max=%0d min=%0d cnt=%0d trunc=%0b, required all 0",
                     out_valid, in_ready, out_max, out_min, out_count, out_trunc);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: in_ready=%0b during reset, required 0", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: in_ready=%0b after first edge, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        push_word(4'd5, 1'b0, 1);
        push_word(4'd10, 1'b0, 1);
        push_word(4'd12, 1'b0, 1);
        push_word(4'd3, 1'b1, 1);
    endtask

    task automatic test_single();
        push_word(4'd9, 1'b1, 0);
    endtask

    task automatic test_equal();
        push_word(4'd12, 1'b0, 0);
        push_word(4'd12, 1'b0, 0);
        push_word(4'd12, 1'b1, 0);
    endtask

    task automatic test_trunc();
        for (int i = 1; i <= 5; i++) push_word(4'(i), 1'b0, 0);
        push_word(4'd8, 1'b1, 0);   // closes the frame opened by word 5
        push_word(4'd2, 1'b0, 0);   // fill to the limit so trunc and last are not confused
        push_word(4'd2, 1'b0, 0);
        push_word(4'd7, 1'b0, 0);
        push_word(4'd1, 1'b1, 0);   // last on word MAX_WORDS: not truncated
    endtask

    task automatic test_stall();
        push_word(4'd3, 1'b0, 0);
        push_word(4'd7, 1'b1, 5);
    endtask

    task automatic test_mid_reset();
        push_word(4'd7, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'd14; in_last = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_max !== '0 || out_min !== '0 ||
            out_count !== '0 || out_trunc !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset: valid=%0b ready=%0b max=%0d min=%0d cnt=%0d trunc=%0b, required all 0",
                     out_valid, in_ready, out_max, out_min, out_count, out_trunc);
        end
        frame_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_word(4'd6, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] d;
        for (int n = 0; n < 80; n++) begin
            d = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(6, 8));
            push_word(d, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end
        push_word(4'($urandom_range(0, 15)), 1'b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_equal();
        test_trunc();
        test_stall();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_minmax_seq

// File: doc/minmax_seq.md
MINMAX_SEQ -- requirements
Module: minmax_seq

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 15, meaning the frame length (in words) at which a frame is force-terminated; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data/in_last are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, 4 bits: unsigned operand word.
REQ-007 The block SHALL have port in_last, input, 1 bit: the word is the last word of its frame.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have ports out_max and out_min, outputs, 4 bits each: the frame maximum and minimum.
REQ-011 The block SHALL have port out_count, output, 4 bits: the number of words in the frame.
REQ-012 The block SHALL have port out_trunc, output, 1 bit: the frame was ended by MAX_WORDS and not by in_last.

Function
REQ-013 The block SHALL use exactly one 4-bit magnitude comparator, time-shared, with gt/eq/lt outputs.
REQ-014 The FSM SHALL have the states S_IDLE, S_CMP_MAX, S_CMP_MIN and S_DONE.
REQ-015 in_ready SHALL be 1 only in S_IDLE; a word transfers when in_valid and in_ready are both 1.
REQ-016 The first word of a frame SHALL load max=min=in_data and count=1; the FSM SHALL then go to S_DONE if the frame ends, else remain in S_IDLE.
REQ-017 Each later word SHALL be latched into hold, increment count, and move the FSM to S_CMP_MAX.
REQ-018 In S_CMP_MAX the comparator inputs SHALL be (hold, max); if gt, max<=hold; the FSM SHALL then move to S_CMP_MIN.
REQ-019 In S_CMP_MIN the comparator inputs SHALL be (hold, min); if lt, min<=hold; the FSM SHALL then go to S_DONE if the frame has ended, else to S_IDLE.
REQ-020 A frame SHALL end on in_last=1, or on acceptance of word number MAX_WORDS; the forced case SHALL set out_trunc=1.
REQ-021 Equal values SHALL leave max and min unchanged.
REQ-022 Each word SHALL cost 3 cycles except the first; a single-word frame SHALL give out_valid on the cycle after acceptance.
REQ-023 In S_DONE, out_valid SHALL be 1 and outputs SHALL be stable; on out_ready=1 the FSM SHALL go to S_IDLE and clear the first-word flag.
REQ-024 A word with in_last=1 arriving after a truncation SHALL start a new single-word frame.

Reset
REQ-025 Asserting rst_n low SHALL immediately force S_IDLE, out_valid=0, out_max=0, out_min=0, out_count=0, out_trunc=0 and hold=0, and SHALL set the first-word flag, including mid-frame.
REQ-026 in_ready SHALL be 0 while rst_n is low and SHALL be 1 on the first clk edge after release.

Configuration
REQ-027 With MINMAX_IDX_EN defined, the block SHALL add outputs out_max_idx and out_min_idx (4 bits each), giving the 0-based position of the first occurrence of each extreme (ties keep the earlier index); both SHALL reset to 0.
REQ-028 Without MINMAX_IDX_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package minmax_pkg SHALL hold the state enum type, WORD_W=4 and CNT_W=4.
REQ-030 The comparator SHALL be a sub-module cmp4 (combinational; inputs a and b; outputs gt, eq and lt), instantiated once.

Verification
REQ-031 Frame 5,10,12,3 (last on 3), out_ready=1 -> max=12, min=3, count=4, trunc=0.
REQ-032 Single word 9 with last=1 -> out_valid on the next cycle; max=min=9, count=1.
REQ-033 Frame 12,12,12 -> max=min=12, count=3; with MINMAX_IDX_EN, max_idx=min_idx=0.
REQ-034 MAX_WORDS=4, five words 1,2,3,4,5 with no last -> first result: max=4, min=1, count=4, trunc=1; word 5 starts a new frame.
REQ-035 out_ready held at 0 for 5 cycles in S_DONE -> outputs stable and in_ready=0 throughout.
REQ-036 rst_n pulled low in S_CMP_MAX of frame 7,14 -> all outputs 0 at once; a later frame 6 (last) -> max=min=6, count=1.
